// File: rtl/netdelay_pipe.sv
// netdelay_pipe
//   Programmable delay line for a WIDTH-bit bus. Each captured sample can be
//   optionally inverted. It then travels through up to DEPTH registered
//   stages, and the output is tapped at the stage selected by cur_delay.
//   A valid bit travels with every sample, so delivered samples can be
//   counted.
//
// Ports
//   clk        rising-edge clock
//   rst        synchronous active-high reset
//   en         advance enable; 0 stalls the whole line and the counter
//   in_valid   x carries a sample this cycle
//   x          input data
//   invert     store ~x instead of x for this sample
//   cfg_load   load a new delay (clamped to 1..DEPTH) and flush in-flight valids
//   cfg_delay  requested delay in cycles
//   y          tapped data (mux of registered stages)
//   y_valid    tapped valid bit
//   cur_delay  delay currently in force
//   out_count  saturating count of delivered valid samples
module netdelay_pipe #(
  parameter int WIDTH     = 32,
  parameter int DEPTH     = 8,
  parameter int RST_DELAY = 1,
  localparam int DW       = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] x,
  input  logic             invert,
  input  logic             cfg_load,
  input  logic [DW-1:0]    cfg_delay,
  output logic [WIDTH-1:0] y,
  output logic             y_valid,
  output logic [DW-1:0]    cur_delay,
  output logic [15:0]      out_count
);

  // Limit a requested delay to the range 1..DEPTH.
  function automatic logic [DW-1:0] clamp_delay(input logic [DW-1:0] d);
    logic [DW-1:0] r;
    if (d == DW'(0)) begin
      r = DW'(1);
    end else if (d > DW'(DEPTH)) begin
      r = DW'(DEPTH);
    end else begin
      r = d;
    end
    return r;
  endfunction

  logic [WIDTH-1:0] s_q [DEPTH];
  logic [WIDTH-1:0] s_d [DEPTH];
  logic [DEPTH-1:0] v_q, v_d;
  logic [DW-1:0]    cur_delay_q, cur_delay_d;
  logic [15:0]      out_count_q, out_count_d;
  logic [DW-1:0]    tap_idx;

  // cur_delay is never 0, so the subtraction cannot underflow.
  assign tap_idx   = cur_delay_q - DW'(1);
  assign cur_delay = cur_delay_q;
  assign out_count = out_count_q;

  // Output tap: select the stage given by cur_delay (no extra register).
  always_comb begin
    y       = '0;
    y_valid = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if (tap_idx == DW'(i)) begin
        y       = s_q[i];
        y_valid = v_q[i];
      end else begin
        // Not the selected stage; keep the current selection.
      end
    end
  end

  // Next-state logic. Reconfiguration beats capture: the line holds its data,
  // all valids are flushed, and no sample is accepted on that edge.
  always_comb begin
    s_d         = s_q;
    v_d         = v_q;
    cur_delay_d = cur_delay_q;
    if (cfg_load) begin
      cur_delay_d = clamp_delay(cfg_delay);
      v_d         = '0;
    end else if (en) begin
      for (int i = 1; i < DEPTH; i++) begin
        s_d[i] = s_q[i-1];
        v_d[i] = v_q[i-1];
      end
      s_d[0] = invert ? ~x : x;
      v_d[0] = in_valid;
    end else begin
      // Stall: everything holds.
    end

    // Delivery counter saturates at all-ones. It is not cleared by cfg_load.
    if (en && y_valid && (out_count_q != 16'hFFFF)) begin
      out_count_d = out_count_q + 16'd1;
    end else begin
      out_count_d = out_count_q;
    end
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        s_q[i] <= '0;
      end
      v_q         <= '0;
      cur_delay_q <= DW'(RST_DELAY);
      out_count_q <= 16'd0;
    end else begin
      s_q         <= s_d;
      v_q         <= v_d;
      cur_delay_q <= cur_delay_d;
      out_count_q <= out_count_d;
    end
  end

endmodule

// File: tb/tb_netdelay_pipe.sv
// Directed-vector bench for netdelay_pipe. The drivers push expected samples,
// each tagged with the enabled-edge count at which it must be delivered, into
// a scoreboard queue. A monitor pops one entry per delivered sample.
module tb_netdelay_pipe;
  localparam int WIDTH = 32;
  localparam int DEPTH = 8;
  localparam int DW    = $clog2(DEPTH + 1);

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             en = 1'b0;
  logic             in_valid = 1'b0;
  logic [WIDTH-1:0] x = '0;
  logic             invert = 1'b0;
  logic             cfg_load = 1'b0;
  logic [DW-1:0]    cfg_delay = '0;
  logic [WIDTH-1:0] y;
  logic             y_valid;
  logic [DW-1:0]    cur_delay;
  logic [15:0]      out_count;

  netdelay_pipe #(.WIDTH(WIDTH), .DEPTH(DEPTH), .RST_DELAY(1)) dut (
    .clk(clk), .rst(rst), .en(en), .in_valid(in_valid), .x(x),
    .invert(invert), .cfg_load(cfg_load), .cfg_delay(cfg_delay),
    .y(y), .y_valid(y_valid), .cur_delay(cur_delay), .out_count(out_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [WIDTH-1:0] data;
    int               due;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   total = 0;
  int   bad = 0;
  int   en_edges = 0;   // edges on which the line advanced
  int   model_delay = 1;

  // Count the edges on which the line advances.
  always @(posedge clk) begin
    if (!rst && en && !cfg_load) en_edges <= en_edges + 1;
  end

  // Monitor: a sample is delivered in any cycle with y_valid=1 and en=1.
  always @(negedge clk) begin
    if (!rst && y_valid && en) begin
      if (sb.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_output y=%h at enabled edge %0d", y, en_edges);
      end else begin
        mon_e = sb.pop_front();
        total++;
        if (y !== mon_e.data) begin
          bad++;
          $display("FAIL sb_data got=%h expected=%h", y, mon_e.data);
        end
        total++;
        if (en_edges != mon_e.due) begin
          bad++;
          $display("FAIL sb_latency got edge=%0d expected edge=%0d", en_edges, mon_e.due);
        end
      end
    end
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [WIDTH-1:0] d, input logic inv, input logic vld);
    exp_t e;
    en       = 1'b1;
    x        = d;
    invert   = inv;
    in_valid = vld;
    if (vld) begin
      e.data = inv ? ~d : d;
      e.due  = en_edges + model_delay;   // capture edge is en_edges+1
      sb.push_back(e);
    end
    tick();
    in_valid = 1'b0;
    invert   = 1'b0;
  endtask

  task automatic idle(input int n);
    en       = 1'b1;
    in_valid = 1'b0;
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic stall(input int n);
    en       = 1'b0;
    in_valid = 1'b1;          // must be ignored while stalled
    x        = 32'hDEAD_BEEF;
    for (int i = 0; i < n; i++) tick();
    in_valid = 1'b0;
    en       = 1'b1;
  endtask

  task automatic load(input logic [DW-1:0] d, input logic [DW-1:0] exp_delay);
    cfg_load  = 1'b1;
    cfg_delay = d;
    in_valid  = 1'b1;         // not accepted on a load edge
    x         = 32'h0BAD_0BAD;
    tick();
    cfg_load  = 1'b0;
    in_valid  = 1'b0;
    sb.delete();
    model_delay = int'(exp_delay);
    check("cur_delay_after_load", 64'(cur_delay), 64'(exp_delay));
    check("y_valid_after_load", 64'(y_valid), 64'd0);
  endtask

  task automatic do_reset();
    rst      = 1'b1;
    cfg_load = 1'b0;
    in_valid = 1'b0;
    tick();
    tick();
    rst = 1'b0;
    sb.delete();
    model_delay = 1;
  endtask

  initial begin
    // Reset state
    do_reset();
    check("rst_y", 64'(y), 64'd0);
    check("rst_y_valid", 64'(y_valid), 64'd0);
    check("rst_cur_delay", 64'(cur_delay), 64'd1);
    check("rst_out_count", 64'(out_count), 64'd0);
    idle(2);
    send(32'h0000_00A5, 1'b0, 1'b1);
    check("default_delay_y", 64'(y), 64'h0000_00A5);
    check("default_delay_valid", 64'(y_valid), 64'd1);
    idle(2);

    // Inversion at delay 3
    load(4'd3, 4'd3);
    send(32'h1234_5678, 1'b1, 1'b1);
    send(32'hCAFE_F00D, 1'b0, 1'b1);
    idle(1);
    check("invert_y", 64'(y), 64'hEDCB_A987);
    check("invert_valid", 64'(y_valid), 64'd1);
    idle(4);
    check("invert_count", 64'(out_count), 64'd3);

    // Stall at delay 4
    do_reset();
    load(4'd4, 4'd4);
    send(32'd1, 1'b0, 1'b1);
    send(32'd2, 1'b0, 1'b1);
    stall(2);
    send(32'd3, 1'b0, 1'b1);
    idle(6);
    check("stall_count", 64'(out_count), 64'd3);

    // Reconfigure flush: 4 samples in flight at delay 5, then delay 2
    load(4'd5, 4'd5);
    for (int i = 0; i < 4; i++) send(32'h100 + 32'(i), 1'b0, 1'b1);
    load(4'd2, 4'd2);
    send(32'h0000_0055, 1'b0, 1'b1);
    idle(1);
    check("flush_new_delay_y", 64'(y), 64'h0000_0055);
    idle(6);
    check("flush_count", 64'(out_count), 64'd4);

    // Clamping
    load(4'd0, 4'd1);
    send(32'h0000_0777, 1'b0, 1'b1);
    idle(2);
    load(4'd11, 4'd8);
    send(32'hA5A5_5A5A, 1'b1, 1'b1);
    idle(10);
    check("clamp_count", 64'(out_count), 64'd6);

    // Reset mid-stream
    for (int i = 0; i < 3; i++) send(32'h200 + 32'(i), 1'b0, 1'b1);
    do_reset();
    idle(10);
    check("midrst_y_valid", 64'(y_valid), 64'd0);
    check("midrst_out_count", 64'(out_count), 64'd0);

    // Saturation: 65 540 deliveries at delay 1
    for (int i = 0; i < 65540; i++) send(32'(i), 1'b0, 1'b1);
    idle(3);
    check("sat_out_count", 64'(out_count), 64'hFFFF);
    check("sb_drained", 64'(sb.size()), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
